pll_reconfig_responder: RTL

//  Responder end of the PLL management bus (mgmt_address/mgmt_write/mgmt_writedata/mgmt_waitrequest).

---
 rtl/pll_reconfig_pkg.sv | 35 +++
 rtl/pll_reconfig_timer.sv | 34 +++
 rtl/pll_reconfig_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the behavioural PLL reconfiguration responder:
// register map, STATUS bit positions, FSM state type and fraction constants.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_FRAC   = 6'd7;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;

    localparam logic [31:0] FRAC_NATIVE = 32'd3639383488;
    localparam logic [31:0] FRAC_60HZ   = 32'd3262113561;

    typedef enum logic [2:0] {
        StIdle,
        StStall,
        StUnlock,
        StApply,
        StRelock
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_busy(input state_e s);
        return (s == StUnlock) || (s == StApply) || (s == StRelock);
    endfunction

endpackage

// File: rtl/pll_reconfig_timer.sv
// Loadable down-counter with a zero flag; a load wins over the decrement and
// the count holds at zero rather than wrapping.
module pll_reconfig_timer #(
    parameter int unsigned Width = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pll_reconfig_responder.sv
// Behavioural PLL reconfiguration responder on the management bus: accepts
// MODE/FRAC/START writes and sequences unlock -> apply -> relock of frac_k.
module pll_reconfig_responder
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned APPLY_CYCLES = 16,
    parameter int unsigned LOCK_CYCLES  = 64,
    parameter int unsigned WR_STALL     = 2,
    parameter logic [31:0] FRAC_RESET   = FRAC_NATIVE
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [31:0] frac_k,
    output logic        locked,
    output logic        apply_strobe
);

    localparam int unsigned CntW = $clog2(max3(APPLY_CYCLES, LOCK_CYCLES, WR_STALL) + 1);
    // Timers count down to zero, so each phase loads its length minus one.
    localparam logic [CntW-1:0] StallLoad = CntW'(WR_STALL - 1);
    localparam logic [CntW-1:0] ApplyLoad = CntW'(APPLY_CYCLES - 1);
    localparam logic [CntW-1:0] LockLoad  = CntW'(LOCK_CYCLES - 1);

    state_e state_d, state_q;

    logic            tmr_load, tmr_zero;
    logic [CntW-1:0] tmr_val;
    logic            bstall_load, bstall_zero, bstall_on_d, bstall_on_q;

    logic        mode_d, mode_q;
    logic        apply_wait_d, apply_wait_q;
    logic        done_d, done_q;
    logic        locked_d, locked_q;
    logic        strobe_d, strobe_q;
    logic        wait_d, wait_q;
    logic [31:0] shadow_d, shadow_q;
    logic [31:0] apply_frac_d, apply_frac_q;
    logic [31:0] frac_k_d, frac_k_q;
    logic [31:0] readdata_d, readdata_q;
    logic [31:0] rd_val;

    logic wr_acc, rd_acc, start_acc, data_wr, busy_q;

    assign wr_acc    = mgmt_write & ~wait_q;
    assign rd_acc    = mgmt_read & ~mgmt_write & ~wait_q;
    assign start_acc = wr_acc & (mgmt_address == ADDR_START);
    assign data_wr   = wr_acc & (mgmt_address != ADDR_START);
    assign busy_q    = is_busy(state_q);

    // Phase timer for STALL/APPLY/RELOCK.
    pll_reconfig_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (mgmt_clk),
        .rst_i      (mgmt_reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Data writes accepted mid-apply (polling mode) stall without leaving the apply sequence.
    assign bstall_load = data_wr & busy_q;

    pll_reconfig_timer #(
        .Width (CntW)
    ) u_busy_stall (
        .clk_i      (mgmt_clk),
        .rst_i      (mgmt_reset),
        .load_i     (bstall_load),
        .load_val_i (StallLoad),
        .zero_o     (bstall_zero)
    );

    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = StUnlock;
                end else if (data_wr) begin
                    state_d  = StStall;
                    tmr_load = 1'b1;
                    tmr_val  = StallLoad;
                end
            end
            StStall: begin
                if (tmr_zero) state_d = StIdle;
            end
            StUnlock: begin
                state_d  = StApply;
                tmr_load = 1'b1;
                tmr_val  = ApplyLoad;
            end
            StApply: begin
                if (tmr_zero) begin
                    state_d  = StRelock;
                    tmr_load = 1'b1;
                    tmr_val  = LockLoad;
                end
            end
            StRelock: begin
                if (tmr_zero) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (mgmt_address)
            ADDR_MODE:   rd_val = {31'b0, mode_q};
            ADDR_STATUS: begin
                rd_val              = '0;
                rd_val[STATUS_BUSY] = busy_q;
                rd_val[STATUS_DONE] = done_q;
            end
            ADDR_FRAC:   rd_val = shadow_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        shadow_d     = shadow_q;
        apply_frac_d = apply_frac_q;
        apply_wait_d = apply_wait_q;
        frac_k_d     = frac_k_q;
        strobe_d     = 1'b0;
        locked_d     = locked_q;
        done_d       = done_q;
        readdata_d   = readdata_q;

        if (wr_acc && mgmt_address == ADDR_MODE) mode_d = mgmt_writedata[0];
        if (wr_acc && mgmt_address == ADDR_FRAC) shadow_d = mgmt_writedata;

        // START while busy is accepted but ignored; the mode is latched per apply.
        if (start_acc && state_q == StIdle) begin
            apply_frac_d = shadow_q;
            apply_wait_d = ~mode_q;
        end

        if (state_q == StUnlock) locked_d = 1'b0;
        if (state_q == StApply && tmr_zero) begin
            frac_k_d = apply_frac_q;
            strobe_d = 1'b1;
        end

        if (rd_acc) begin
            readdata_d = rd_val;
            if (mgmt_address == ADDR_STATUS) done_d = 1'b0;
        end
        // Completion sets done after any clear so a same-cycle read cannot lose it.
        if (state_q == StRelock && tmr_zero) begin
            locked_d = 1'b1;
            done_d   = 1'b1;
        end

        bstall_on_d = bstall_load | (bstall_on_q & ~bstall_zero);
        wait_d      = (state_d == StStall) | (is_busy(state_d) & apply_wait_d) | bstall_on_d;
    end

    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            mode_q       <= 1'b0;
            shadow_q     <= FRAC_RESET;
            apply_frac_q <= FRAC_RESET;
            apply_wait_q <= 1'b0;
            frac_k_q     <= FRAC_RESET;
            strobe_q     <= 1'b0;
            locked_q     <= 1'b1;
            done_q       <= 1'b0;
            readdata_q   <= '0;
            bstall_on_q  <= 1'b0;
            wait_q       <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            shadow_q     <= shadow_d;
            apply_frac_q <= apply_frac_d;
            apply_wait_q <= apply_wait_d;
            frac_k_q     <= frac_k_d;
            strobe_q     <= strobe_d;
            locked_q     <= locked_d;
            done_q       <= done_d;
            readdata_q   <= readdata_d;
            bstall_on_q  <= bstall_on_d;
            wait_q       <= wait_d;
        end
    end

    assign mgmt_readdata    = readdata_q;
    assign mgmt_waitrequest = wait_q;
    assign frac_k           = frac_k_q;
    assign locked           = locked_q;
    assign apply_strobe     = strobe_q;

endmodule
